hdmi_to_blocks: RTL and testbench

HDMI_TO_BLOCKS -- requirements
Module: hdmi_to_blocks

---
 rtl/hdmi_to_blocks.sv | 230 +++++++++++++++++++++++
 tb/tb_hdmi_to_blocks.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_to_blocks.sv
// hdmi_to_blocks: turns a raster pixel stream (N pixels per beat) into 8x8
// blocks. Each 8-line band is stored in one of two ping-pong banks. When a
// band's row 7 is complete, the bank is handed to the read side, which bursts
// it out block by block, left to right, with N pixels per beat.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   en                          0 = ignore raster input (write side held in W_SYNC)
//   hdmi_v_sync, hdmi_h_sync    syncs, active high (h_sync is not used)
//   hdmi_data_valid             active-pixel beat qualifier
//   hdmi_data_y/cr/cb           N lanes of 8 bits, lane 0 = leftmost pixel
//   blk_valid                   block beat valid
//   blk_data_y/cr/cb            block beat lanes
//   blk_sob, blk_eob, blk_sof   first/last beat of a block, first beat of a frame
//   fmt_err                     one-cycle pulse on a raster format violation
//
// Write FSM
//   state  | meaning
//   W_SYNC | idle, waiting for a v_sync rising edge
//   W_LINE | storing beats of the current band
//   W_DONE | last band stored, waiting for the next v_sync rising edge
// Read FSM
//   state   | meaning
//   R_IDLE  | no band to emit
//   R_BURST | emitting one band, one beat per cycle
module hdmi_to_blocks #(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  hdmi_v_sync,
  input  logic                  hdmi_h_sync,
  input  logic                  hdmi_data_valid,
  input  logic signed [N*8-1:0] hdmi_data_y,
  input  logic signed [N*8-1:0] hdmi_data_cr,
  input  logic signed [N*8-1:0] hdmi_data_cb,
  output logic                  blk_valid,
  output logic signed [N*8-1:0] blk_data_y,
  output logic signed [N*8-1:0] blk_data_cr,
  output logic signed [N*8-1:0] blk_data_cb,
  output logic                  blk_sob,
  output logic                  blk_eob,
  output logic                  blk_sof,
  output logic                  fmt_err
);

  localparam int BPL   = X_RES / N;     // beats per line
  localparam int BPR   = 8 / N;         // beats per block row
  localparam int BPB   = 64 / N;        // beats per block
  localparam int BANDS = Y_RES / 8;
  localparam int WORDS = 8 * BPL;       // words per bank == beats per band
  localparam int AW    = $clog2(WORDS);
  localparam int CW    = $clog2(BPL + 1);
  localparam int BW    = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int DW    = 3 * N * 8;

  localparam logic [1:0] W_SYNC  = 2'd0;
  localparam logic [1:0] W_LINE  = 2'd1;
  localparam logic [1:0] W_DONE  = 2'd2;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  logic [1:0]    w_state;
  logic [0:0]    r_state;
  logic          vs_d, dv_d;
  logic [CW-1:0] col;
  logic          line_over;
  logic [2:0]    row;
  logic [BW-1:0] band;
  logic          wbank, rbank;
  logic [AW-1:0] rd_cnt;
  logic          rd_first_band;

  logic [DW-1:0] mem [2][WORDS];

  logic          unused_h_sync;
  assign unused_h_sync = hdmi_h_sync;

  logic vs_rise, dv_fall, in_line, wr_en, line_end, line_bad;
  logic band_end, start_rd, overrun, abort;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] rd_word;
  int unsigned   rd_k, rd_j;

  assign vs_rise  = hdmi_v_sync & ~vs_d;
  assign dv_fall  = dv_d & ~hdmi_data_valid;
  assign in_line  = en && (w_state == W_LINE) && !vs_rise;
  assign wr_en    = in_line && hdmi_data_valid && (col < CW'(BPL));
  assign line_end = in_line && dv_fall;
  assign line_bad = line_end && ((col != CW'(BPL)) || line_over);
  assign band_end = line_end && (row == 3'd7);
  assign start_rd = band_end && (r_state == R_IDLE);
  // A band finishing while the previous one is still bursting is dropped.
  assign overrun  = band_end && (r_state == R_BURST);
  assign abort    = en && (w_state == W_LINE) && vs_rise;

  assign wr_addr = AW'(32'(row) * BPL + 32'(col));

  // Beat k of block j reads row k/BPR, beat column j*BPR + k%BPR.
  always_comb begin
    rd_j    = 32'(rd_cnt) / BPB;
    rd_k    = 32'(rd_cnt) % BPB;
    rd_addr = AW'((rd_k / BPR) * BPL + rd_j * BPR + (rd_k % BPR));
  end

  assign rd_word = mem[rbank][rd_addr];

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wbank][wr_addr] <= {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_SYNC;
      vs_d      <= 1'b0;
      dv_d      <= 1'b0;
      col       <= '0;
      line_over <= 1'b0;
      row       <= '0;
      band      <= '0;
      wbank     <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      vs_d    <= hdmi_v_sync;
      dv_d    <= hdmi_data_valid;
      fmt_err <= line_bad | overrun | abort;
      if (!en) begin
        w_state   <= W_SYNC;
        col       <= '0;
        line_over <= 1'b0;
        row       <= '0;
        band      <= '0;
      end else begin
        case (w_state)
          W_SYNC, W_DONE: begin
            if (vs_rise) begin
              w_state   <= W_LINE;
              col       <= '0;
              line_over <= 1'b0;
              row       <= '0;
              band      <= '0;
            end
          end
          W_LINE: begin
            if (vs_rise) begin
              // Early frame start: discard the partial band, keep the bank.
              col       <= '0;
              line_over <= 1'b0;
              row       <= '0;
              band      <= '0;
            end else begin
              if (hdmi_data_valid) begin
                if (col < CW'(BPL)) col <= col + CW'(1);
                else                line_over <= 1'b1;
              end
              if (dv_fall) begin
                col       <= '0;
                line_over <= 1'b0;
                if (row == 3'd7) begin
                  row <= '0;
                  if (start_rd) wbank <= ~wbank;
                  if (band == BW'(BANDS - 1)) begin
                    band    <= '0;
                    w_state <= W_DONE;
                  end else begin
                    band <= band + BW'(1);
                  end
                end else begin
                  row <= row + 3'd1;
                end
              end
            end
          end
          default: w_state <= W_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      rbank         <= 1'b0;
      rd_cnt        <= '0;
      rd_first_band <= 1'b0;
      blk_valid     <= 1'b0;
      blk_sob       <= 1'b0;
      blk_eob       <= 1'b0;
      blk_sof       <= 1'b0;
      blk_data_y    <= '0;
      blk_data_cr   <= '0;
      blk_data_cb   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          blk_valid   <= 1'b0;
          blk_sob     <= 1'b0;
          blk_eob     <= 1'b0;
          blk_sof     <= 1'b0;
          blk_data_y  <= '0;
          blk_data_cr <= '0;
          blk_data_cb <= '0;
          if (start_rd) begin
            r_state       <= R_BURST;
            rbank         <= wbank;
            rd_cnt        <= '0;
            rd_first_band <= (band == '0);
          end
        end
        R_BURST: begin
          blk_valid   <= 1'b1;
          blk_data_y  <= rd_word[N*8-1:0];
          blk_data_cr <= rd_word[2*N*8-1:N*8];
          blk_data_cb <= rd_word[3*N*8-1:2*N*8];
          blk_sob     <= (rd_k == 0);
          blk_eob     <= (rd_k == BPB - 1);
          blk_sof     <= rd_first_band && (rd_cnt == '0);
          rd_cnt      <= rd_cnt + AW'(1);
          if (rd_cnt == AW'(WORDS - 1)) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_to_blocks.sv
module tb_hdmi_to_blocks;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic vs = 1'b0;
  logic hs = 1'b0;
  logic dv = 1'b0;
  logic [15:0] dy = '0, dcr = '0, dcb = '0;
  logic blk_valid, blk_sob, blk_eob, blk_sof, fmt_err;
  logic [15:0] oy, ocr, ocb;

  hdmi_to_blocks #(.N(2), .X_RES(16), .Y_RES(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hdmi_v_sync(vs), .hdmi_h_sync(hs), .hdmi_data_valid(dv),
    .hdmi_data_y(dy), .hdmi_data_cr(dcr), .hdmi_data_cb(dcb),
    .blk_valid(blk_valid), .blk_data_y(oy), .blk_data_cr(ocr), .blk_data_cb(ocb),
    .blk_sob(blk_sob), .blk_eob(blk_eob), .blk_sof(blk_sof), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] y, cr, cb;
    logic sob, eob, sof, first;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int n_pass = 0, n_tot = 0;
  int cyc = 0, line_last_cyc = 0;
  int err_cnt = 0, beat_cnt = 0, sof_cnt = 0, sob_cnt = 0, eob_cnt = 0;
  logic [15:0] cap [128];
  int cap_n = 0;
  bit cap_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [7:0] pix(input int x, input int yy);
    return 8'(x + 16 * yy);
  endfunction
  function automatic logic [15:0] lanes_y(input int x0, input int yy);
    return {pix(x0 + 1, yy), pix(x0, yy)};
  endfunction
  function automatic logic [15:0] lanes_cr(input int x0, input int yy);
    return {~pix(x0 + 1, yy), ~pix(x0, yy)};
  endfunction
  function automatic logic [15:0] lanes_cb(input int x0, input int yy);
    return {pix(x0 + 1, yy) ^ 8'h3C, pix(x0, yy) ^ 8'h3C};
  endfunction

  // Expected 64 beats of band b: two blocks of 32 beats, 4 beats per block row.
  task automatic push_band(input int b);
    for (int n = 0; n < 64; n++) begin
      beat_t e;
      int j, k, r, x0;
      j = n / 32;
      k = n % 32;
      r = k / 4;
      x0 = j * 8 + (k % 4) * 2;
      e.y = lanes_y(x0, b * 8 + r);
      e.cr = lanes_cr(x0, b * 8 + r);
      e.cb = lanes_cb(x0, b * 8 + r);
      e.sob = (k == 0);
      e.eob = (k == 31);
      e.sof = (b == 0) && (n == 0);
      e.first = (n == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_line(input int yy, input int nb);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      dv = 1'b1;
      dy = lanes_y(2 * b, yy);
      dcr = lanes_cr(2 * b, yy);
      dcb = lanes_cb(2 * b, yy);
      line_last_cyc = cyc;
    end
    @(negedge clk);
    dv = 1'b0;
    hs = 1'b1;
    @(negedge clk);
    hs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_vsync();
    @(negedge clk);
    vs = 1'b1;
    repeat (2) @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_rows(input int y0, input int y1, input int short_y, input bit push);
    for (int yy = y0; yy < y1; yy++) begin
      if (push && (yy % 8 == 7)) push_band(yy / 8);
      send_line(yy, (yy == short_y) ? 7 : 8);
    end
  endtask

  task automatic clear_counts();
    sof_cnt = 0;
    sob_cnt = 0;
    eob_cnt = 0;
    beat_cnt = 0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || blk_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_sof_count"}, 64'(sof_cnt), 64'd1);
    chk({tag, "_sob_count"}, 64'(sob_cnt), 64'd4);
    chk({tag, "_eob_count"}, 64'(eob_cnt), 64'd4);
    chk({tag, "_beat_count"}, 64'(beat_cnt), 64'd128);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (fmt_err) err_cnt++;
      if (blk_valid) begin
        beat_cnt++;
        if (blk_sof) sof_cnt++;
        if (blk_sob) sob_cnt++;
        if (blk_eob) eob_cnt++;
        if (cap_en && cap_n < 128) begin
          cap[cap_n] = oy;
          cap_n++;
        end
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_beat: got blk_valid=1 y=%0h at cycle %0d, expected no output", oy, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 64'({oy, ocr, ocb}), 64'({mon_e.y, mon_e.cr, mon_e.cb}));
          chk("beat_flags", 64'({blk_sob, blk_eob, blk_sof}), 64'({mon_e.sob, mon_e.eob, mon_e.sof}));
          if (mon_e.first) chk("band_latency", 64'(cyc - line_last_cyc), 64'd3);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bit hit;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({blk_valid, blk_sob, blk_eob, blk_sof, fmt_err, oy, ocr, ocb}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame with hand-checked beats
    clear_counts();
    cap_n = 0;
    cap_en = 1;
    e0 = err_cnt;
    send_vsync();
    send_rows(0, 16, -1, 1);
    wait_drain("frameA_drain");
    cap_en = 0;
    check_frame("frameA");
    chk("frameA_no_err", 64'(err_cnt - e0), 64'd0);
    chk("blk0_beat0", 64'(cap[0]), 64'h0100);
    chk("blk0_beat4", 64'(cap[4]), 64'h1110);
    chk("blk1_beat0", 64'(cap[32]), 64'h0908);
    chk("blk2_beat0", 64'(cap[64]), 64'h8180);

    // Line 3 short by one beat; the missing word keeps the previous frame's data
    clear_counts();
    e0 = err_cnt;
    send_vsync();
    send_rows(0, 4, 3, 1);
    chk("short_line_err", 64'(err_cnt - e0), 64'd1);
    send_rows(4, 16, 3, 1);
    wait_drain("frameB_drain");
    check_frame("frameB");

    // Early v_sync after 5 lines; that v_sync starts the next frame
    clear_counts();
    e0 = err_cnt;
    send_vsync();
    send_rows(0, 5, -1, 0);
    send_vsync();
    chk("early_vsync_err", 64'(err_cnt - e0), 64'd1);
    chk("partial_band_no_output", 64'(beat_cnt), 64'd0);
    send_rows(0, 16, -1, 1);
    wait_drain("frameC_drain");
    check_frame("frameC");

    // Disabled for a whole frame, then enabled before the next v_sync
    clear_counts();
    @(negedge clk);
    en = 1'b0;
    send_vsync();
    send_rows(0, 16, -1, 0);
    repeat (20) @(negedge clk);
    chk("en0_no_output", 64'(beat_cnt), 64'd0);
    en = 1'b1;
    send_vsync();
    send_rows(0, 16, -1, 1);
    wait_drain("frameD_drain");
    check_frame("frameD");

    // Reset during beat 10 of block 1
    clear_counts();
    send_vsync();
    send_rows(0, 8, -1, 1);
    hit = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #2;
      if (blk_valid && beat_cnt == 42) begin
        hit = 1;
        break;
      end
    end
    chk("reset_trigger_found", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({blk_valid, blk_sob, blk_eob, blk_sof, fmt_err, oy, ocr, ocb}), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    send_rows(0, 16, -1, 0);
    repeat (20) @(negedge clk);
    chk("no_output_before_vsync", 64'(beat_cnt), 64'd0);
    send_vsync();
    send_rows(0, 16, -1, 1);
    wait_drain("frameE_drain");
    check_frame("frameE");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
